regex_stream_ctx_mgr: RTL and testbench

//  Per-stream context manager for one DFA regex matcher in the packet-inspection datapath.

---
 rtl/regex_stream_ctx_mgr_if.sv | 39 +++
 rtl/regex_stream_ctx_mgr.sv | 221 ++++++++++++++++++++++
 tb/tb_regex_stream_ctx_mgr.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/regex_stream_ctx_mgr_if.sv
// Bundle of packet-side, DFA-side and count-read signals for the regex stream context manager.
// The slave modport is the context manager's view; master is the surrounding datapath's view.
interface regex_stream_ctx_mgr_if #(
    parameter int SID_W   = 6,
    parameter int STATE_W = 11,
    parameter int CHAR_W  = 8,
    parameter int CNT_W   = 16
);
    logic               load_state;
    logic [SID_W-1:0]   stream_id;
    logic               new_stream_id;
    logic               enable;
    logic [CHAR_W-1:0]  char_in;
    logic               char_in_vld;
    logic               eop;
    logic               busy;
    logic               fired;
    logic [CHAR_W-1:0]  dfa_char;
    logic               dfa_char_vld;
    logic [STATE_W-1:0] dfa_state_in;
    logic               dfa_state_in_vld;
    logic [STATE_W-1:0] dfa_state_out;
    logic               dfa_accept;
    logic [SID_W-1:0]   rd_sid;
    logic [CNT_W-1:0]   rd_count;
    logic               cnt_clr;

    modport master (
        output load_state, stream_id, new_stream_id, enable, char_in, char_in_vld, eop,
        output dfa_state_out, dfa_accept, rd_sid, cnt_clr,
        input  busy, fired, dfa_char, dfa_char_vld, dfa_state_in, dfa_state_in_vld, rd_count
    );

    modport slave (
        input  load_state, stream_id, new_stream_id, enable, char_in, char_in_vld, eop,
        input  dfa_state_out, dfa_accept, rd_sid, cnt_clr,
        output busy, fired, dfa_char, dfa_char_vld, dfa_state_in, dfa_state_in_vld, rd_count
    );
endinterface

// File: rtl/regex_stream_ctx_mgr.sv
// Per-stream context manager for one DFA regex matcher: restores saved DFA state at packet
// start, tracks matches, and commits state plus a saturating match count once the DFA drains.
module regex_stream_ctx_mgr #(
    parameter int NUM_STREAMS = 64,
    parameter int SID_W       = 6,
    parameter int STATE_W     = 11,
    parameter int CHAR_W      = 8,
    parameter int CNT_W       = 16,
    parameter int DFA_LAT     = 1
) (
    input logic                    clk,
    input logic                    rst,
    regex_stream_ctx_mgr_if.slave  io
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_COMMIT} state_e;

    localparam int DRAIN_CYC = DFA_LAT + 2;
    localparam int DCNT_W    = $clog2(DRAIN_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e              state_q, state_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic                eop_pend_q, eop_pend_d;
    logic [SID_W-1:0]    sid_q, sid_d;
    logic                en_q, en_d;
    logic                zero_q, zero_d;
    logic                fwd_q, fwd_d;
    logic [STATE_W-1:0]  fwd_st_q, fwd_st_d;
    logic                vld_rd_q, vld_rd_d;
    logic                ld_stb_q, ld_stb_d;
    logic [CHAR_W-1:0]   dfa_char_q, dfa_char_d;
    logic                dfa_char_vld_q, dfa_char_vld_d;
    logic                acc_r_q, acc_r_d;
    logic [STATE_W-1:0]  st_r_q, st_r_d;
    logic                fired_q, fired_d;
    logic [CNT_W-1:0]    rd_count_q, rd_count_d;
    logic [STATE_W-1:0]  ram_rd_q;

    logic                busy, in_commit, in_match_win;
    logic                load_acc, sid_ok, wr_en;
    logic [CNT_W-1:0]    count_inc;
    logic [CNT_W-1:0]    count_vec [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] valid_vec;
    logic [STATE_W-1:0]  state_mem [NUM_STREAMS];

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            dcnt_q     <= '0;
            eop_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dcnt_q     <= dcnt_d;
            eop_pend_q <= eop_pend_d;
        end
    end

    // FSM: next state; a load in the COMMIT cycle chains straight into the next packet
    always_comb begin
        state_d    = state_q;
        dcnt_d     = dcnt_q;
        eop_pend_d = eop_pend_q;
        case (state_q)
            S_IDLE, S_COMMIT: begin
                state_d = S_IDLE;
                if (load_acc) begin
                    state_d    = S_RUN;
                    eop_pend_d = io.eop;
                end
            end
            S_RUN: begin
                if (io.eop || eop_pend_q) begin
                    state_d    = S_DRAIN;
                    dcnt_d     = DCNT_W'(DRAIN_CYC - 1);
                    eop_pend_d = 1'b0;
                end
            end
            S_DRAIN: begin
                if (dcnt_q == '0) state_d = S_COMMIT;
                else              dcnt_d  = dcnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy         = 1'b0;
        in_commit    = 1'b0;
        in_match_win = 1'b0;
        case (state_q)
            S_RUN, S_DRAIN: begin
                busy         = 1'b1;
                in_match_win = 1'b1;
            end
            S_COMMIT: in_commit = 1'b1;
            default: ;
        endcase
    end

    assign load_acc  = io.load_state && !busy;
    assign sid_ok    = int'(sid_q) < NUM_STREAMS;
    assign wr_en     = in_commit && en_q && sid_ok;
    assign count_inc = (count_vec[sid_q] == CNT_MAX) ? CNT_MAX
                                                     : count_vec[sid_q] + CNT_W'(fired_q);

    always_comb begin
        sid_d          = sid_q;
        en_d           = en_q;
        zero_d         = zero_q;
        fwd_d          = fwd_q;
        fwd_st_d       = fwd_st_q;
        vld_rd_d       = vld_rd_q;
        ld_stb_d       = load_acc;
        dfa_char_d     = io.char_in;
        dfa_char_vld_d = io.char_in_vld;
        acc_r_d        = io.dfa_accept;
        st_r_d         = io.dfa_state_out;
        if (load_acc) begin
            sid_d    = io.stream_id;
            en_d     = io.enable;
            zero_d   = io.new_stream_id || (int'(io.stream_id) >= NUM_STREAMS);
            // The RAM write from a same-cycle commit lands too late for the read; bypass it
            fwd_d    = wr_en && (io.stream_id == sid_q);
            fwd_st_d = st_r_q;
            vld_rd_d = valid_vec[io.stream_id];
        end
    end

    always_comb begin
        fired_d = fired_q;
        if (in_match_win && acc_r_q) fired_d = 1'b1;
        if (in_commit && !en_q)      fired_d = 1'b0;
        if (load_acc)                fired_d = 1'b0;
    end

    always_comb begin
        rd_count_d = count_vec[io.rd_sid];
        if (io.cnt_clr)                       rd_count_d = '0;
        else if (wr_en && io.rd_sid == sid_q) rd_count_d = count_inc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sid_q          <= '0;
            en_q           <= 1'b0;
            zero_q         <= 1'b1;
            fwd_q          <= 1'b0;
            fwd_st_q       <= '0;
            vld_rd_q       <= 1'b0;
            ld_stb_q       <= 1'b0;
            dfa_char_q     <= '0;
            dfa_char_vld_q <= 1'b0;
            acc_r_q        <= 1'b0;
            st_r_q         <= '0;
            fired_q        <= 1'b0;
            rd_count_q     <= '0;
        end else begin
            sid_q          <= sid_d;
            en_q           <= en_d;
            zero_q         <= zero_d;
            fwd_q          <= fwd_d;
            fwd_st_q       <= fwd_st_d;
            vld_rd_q       <= vld_rd_d;
            ld_stb_q       <= ld_stb_d;
            dfa_char_q     <= dfa_char_d;
            dfa_char_vld_q <= dfa_char_vld_d;
            acc_r_q        <= acc_r_d;
            st_r_q         <= st_r_d;
            fired_q        <= fired_d;
            rd_count_q     <= rd_count_d;
        end
    end

    // Saved DFA state: block RAM, never reset; valid bits gate stale contents
    always_ff @(posedge clk) begin
        if (wr_en)    state_mem[sid_q] <= st_r_q;
        if (load_acc) ram_rd_q <= state_mem[io.stream_id];
    end

    genvar gi;
    for (gi = 0; gi < NUM_STREAMS; gi++) begin : g_ctx
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             vld_q, vld_d;
        logic             hit;

        assign hit = wr_en && (sid_q == SID_W'(gi));

        always_comb begin
            cnt_d = cnt_q;
            vld_d = vld_q;
            if (io.cnt_clr) cnt_d = '0;
            else if (hit)   cnt_d = count_inc;
            if (hit)        vld_d = 1'b1;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
                vld_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                vld_q <= vld_d;
            end
        end

        assign count_vec[gi] = cnt_q;
        assign valid_vec[gi] = vld_q;
    end

    assign io.busy             = busy;
    assign io.fired            = fired_q;
    assign io.dfa_char         = dfa_char_q;
    assign io.dfa_char_vld     = dfa_char_vld_q;
    assign io.dfa_state_in_vld = ld_stb_q;
    assign io.dfa_state_in     = zero_q   ? '0       :
                                 fwd_q    ? fwd_st_q :
                                 vld_rd_q ? ram_rd_q : '0;
    assign io.rd_count         = rd_count_q;
endmodule

// File: tb/tb_regex_stream_ctx_mgr.sv
// Directed bench for regex_stream_ctx_mgr with a toy DFA: state accumulates char codes,
// accept fires one cycle after a '!' character. Counter narrowed so saturation is reachable.
`timescale 1ns/1ps
module tb_regex_stream_ctx_mgr;
    localparam int NUM_STREAMS = 64;
    localparam int SID_W       = 6;
    localparam int STATE_W     = 11;
    localparam int CHAR_W      = 8;
    localparam int CNT_W       = 4;
    localparam int DFA_LAT     = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regex_stream_ctx_mgr_if #(.SID_W(SID_W), .STATE_W(STATE_W), .CHAR_W(CHAR_W), .CNT_W(CNT_W)) bus ();

    regex_stream_ctx_mgr #(
        .NUM_STREAMS(NUM_STREAMS), .SID_W(SID_W), .STATE_W(STATE_W),
        .CHAR_W(CHAR_W), .CNT_W(CNT_W), .DFA_LAT(DFA_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    logic [STATE_W-1:0] dfa_st = '0;
    logic               dfa_acc = 1'b0;
    always @(posedge clk) begin
        if (bus.dfa_state_in_vld)  dfa_st <= bus.dfa_state_in;
        else if (bus.dfa_char_vld) dfa_st <= dfa_st + STATE_W'(bus.dfa_char);
        dfa_acc <= bus.dfa_char_vld && (bus.dfa_char == 8'h21);
    end
    assign bus.dfa_state_out = dfa_st;
    assign bus.dfa_accept    = dfa_acc;

    int                 sin_cnt = 0;
    logic [STATE_W-1:0] last_sin = '1;
    always @(negedge clk) begin
        if (bus.dfa_state_in_vld === 1'b1) begin
            last_sin = bus.dfa_state_in;
            sin_cnt  = sin_cnt + 1;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        $display("check %-16s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load on the current cycle, then n chars (first char in the top byte used), eop on the last
    task automatic pkt(input int sid, input bit nw, input bit en, input logic [31:0] chars, input int n);
        logic [31:0] c;
        c = chars;
        last_sin          = '1;
        bus.load_state    = 1'b1;
        bus.stream_id     = SID_W'(sid);
        bus.new_stream_id = nw;
        bus.enable        = en;
        tick();
        bus.load_state = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.char_in     = c[8*(n-1-i) +: 8];
            bus.char_in_vld = 1'b1;
            bus.eop         = (i == n - 1);
            tick();
        end
        bus.char_in_vld = 1'b0;
        bus.eop         = 1'b0;
    endtask

    int s0;

    initial begin
        bus.load_state    = 1'b0;
        bus.stream_id     = '0;
        bus.new_stream_id = 1'b0;
        bus.enable        = 1'b0;
        bus.char_in       = '0;
        bus.char_in_vld   = 1'b0;
        bus.eop           = 1'b0;
        bus.rd_sid        = 6'd5;
        bus.cnt_clr       = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        chk("rst_busy",    32'(bus.busy), 32'h0);
        chk("rst_fired",   32'(bus.fired), 32'h0);
        chk("rst_char_vld", 32'(bus.dfa_char_vld), 32'h0);
        chk("rst_sin_vld", 32'(bus.dfa_state_in_vld), 32'h0);
        chk("rst_rd_count", 32'(bus.rd_count), 32'h0);

        // T1: fresh stream 5, "GET!" -> state 0x101, match counted
        pkt(5, 1'b1, 1'b1, 32'h4745_5421, 4);
        chk("t1_sin", 32'(last_sin), 32'h0);
        repeat (3) tick();
        chk("t1_fired_commit", 32'(bus.fired), 32'h1);
        chk("t1_busy_commit",  32'(bus.busy), 32'h0);
        tick();
        chk("t1_rd_count", 32'(bus.rd_count), 32'h1);

        // T2: stream 3 "AB" -> 0x83 saved, resumed by a second packet
        pkt(3, 1'b1, 1'b1, 32'h0000_4142, 2);
        chk("t2_sin_first", 32'(last_sin), 32'h0);
        repeat (4) tick();
        pkt(3, 1'b0, 1'b1, 32'h0000_0043, 1);
        chk("t2_sin_resume", 32'(last_sin), 32'h83);
        repeat (4) tick();

        // T3: stream 7 saves 0x45, resumes to 0x89, reload in COMMIT cycle sees 0x89
        pkt(7, 1'b1, 1'b1, 32'h0000_0045, 1);
        repeat (4) tick();
        pkt(7, 1'b0, 1'b1, 32'h0000_0044, 1);
        chk("t3_sin_ram", 32'(last_sin), 32'h45);
        repeat (3) tick();
        chk("t3_busy_commit", 32'(bus.busy), 32'h0);
        pkt(7, 1'b0, 1'b1, 32'h0000_0046, 1);
        chk("t3_sin_fwd", 32'(last_sin), 32'h89);
        repeat (4) tick();

        // T4: disabled packet on stream 5 with a match: fired until commit, nothing written
        pkt(5, 1'b0, 1'b0, 32'h0000_0021, 1);
        chk("t4_sin", 32'(last_sin), 32'h101);
        repeat (3) tick();
        chk("t4_fired_commit", 32'(bus.fired), 32'h1);
        tick();
        chk("t4_fired_after", 32'(bus.fired), 32'h0);
        chk("t4_rd_count", 32'(bus.rd_count), 32'h1);
        pkt(5, 1'b0, 1'b1, 32'h0000_005A, 1);
        chk("t4_state_kept", 32'(last_sin), 32'h101);
        repeat (4) tick();

        // T5: saturate stream 2 at 15, then clear in the same cycle as a commit
        bus.rd_sid = 6'd2;
        for (int k = 0; k < 15; k++) begin
            pkt(2, (k == 0), 1'b1, 32'h0000_0021, 1);
            repeat (4) tick();
        end
        chk("t5_count_max", 32'(bus.rd_count), 32'hF);
        pkt(2, 1'b0, 1'b1, 32'h0000_0021, 1);
        repeat (4) tick();
        chk("t5_saturated", 32'(bus.rd_count), 32'hF);
        pkt(2, 1'b0, 1'b1, 32'h0000_0021, 1);
        repeat (3) tick();
        bus.cnt_clr = 1'b1;
        tick();
        bus.cnt_clr = 1'b0;
        chk("t5_clr_fwd", 32'(bus.rd_count), 32'h0);
        tick();
        chk("t5_clr_mem", 32'(bus.rd_count), 32'h0);
        bus.rd_sid = 6'd5;
        tick();
        chk("t5_clr_other", 32'(bus.rd_count), 32'h0);
        pkt(2, 1'b0, 1'b1, 32'h0000_0021, 1);
        chk("t5_state_kept", 32'(last_sin), 32'h231);
        repeat (4) tick();

        // T6: load while busy is dropped; reset mid-packet discards it and clears valid bits
        s0 = sin_cnt;
        bus.rd_sid        = 6'd9;
        bus.load_state    = 1'b1;
        bus.stream_id     = 6'd9;
        bus.new_stream_id = 1'b1;
        bus.enable        = 1'b1;
        tick();
        bus.stream_id     = 6'd10;
        bus.new_stream_id = 1'b0;
        bus.char_in       = 8'h21;
        bus.char_in_vld   = 1'b1;
        tick();
        bus.load_state  = 1'b0;
        bus.char_in_vld = 1'b0;
        chk("t6_busy_run", 32'(bus.busy), 32'h1);
        repeat (3) tick();
        chk("t6_fired_run", 32'(bus.fired), 32'h1);
        chk("t6_one_strobe", 32'(sin_cnt - s0), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_busy_rst",  32'(bus.busy), 32'h0);
        chk("t6_fired_rst", 32'(bus.fired), 32'h0);
        tick();
        chk("t6_rd_count", 32'(bus.rd_count), 32'h0);
        pkt(3, 1'b0, 1'b1, 32'h0000_0041, 1);
        chk("t6_valid_clr", 32'(last_sin), 32'h0);
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
